// File: rtl/fetch_queue.sv
// Instruction fetch unit with a small FIFO queue toward decode.
// Keeps at most one imem request in flight and discards responses orphaned by a redirect.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h40000060,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dq_valid,
  output logic [31:0] dq_instr,
  output logic [31:0] dq_pc,
  input  logic        dq_ready
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(QDEPTH);

  typedef enum logic [1:0] {FETCH, STALL, DROP} state_t;

  state_t           state;
  logic [31:0]      fetch_pc;
  logic [31:0]      drop_addr;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [31:0]      q_instr [QDEPTH];
  logic [31:0]      q_pc    [QDEPTH];
  logic             enq;
  logic             deq;

  // State-derived outputs; reset gating keeps them quiet during the reset cycle itself.
  assign imem_read    = !rst && (state != STALL);
  assign imem_address = (state == DROP) ? drop_addr : fetch_pc;
  assign dq_valid     = !rst && (count != '0) && !redirect;
  assign dq_instr     = q_instr[head];
  assign dq_pc        = q_pc[head];
  assign deq          = dq_valid && dq_ready;
  assign enq          = !rst && !redirect && (state == FETCH) && imem_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      case (state)
        FETCH: begin
          // An unanswered request must be drained before the new target is fetched.
          if (!imem_resp) begin
            state     <= DROP;
            drop_addr <= fetch_pc;
          end
        end
        STALL:   state <= FETCH;
        DROP:    if (imem_resp) state <= FETCH;
        default: state <= FETCH;
      endcase
    end else begin
      if (deq) head <= head + PTR_W'(1);
      if (enq) tail <= tail + PTR_W'(1);
      count <= count + CNT_W'(enq) - CNT_W'(deq);
      case (state)
        FETCH: begin
          if (imem_resp) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (!deq && (count == FULL - CNT_W'(1))) state <= STALL;
          end
        end
        STALL:   if (deq) state <= FETCH;
        DROP:    if (imem_resp) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // Queue storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_instr[tail] <= imem_rdata;
      q_pc[tail]    <= fetch_pc;
    end
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter RESET_PC, default 32'h40000060; the PC of the first fetch after reset.
REQ-002 Parameter QDEPTH, default 4; instruction-queue entries, power of two, at least 2.
REQ-003 Port clk  in  1  clock; all state updates on the rising edge.
REQ-004 Port rst  in  1  synchronous, active-high reset.
REQ-005 Port imem_read  out  1  instruction-memory read request; held until imem_resp.
REQ-006 Port imem_address  out  32  fetch address; word-aligned; stable while imem_read=1.
REQ-007 Port imem_resp  in  1  one-cycle pulse; imem_rdata valid this cycle.
REQ-008 Port imem_rdata  in  32  fetched instruction word.
REQ-009 Port redirect  in  1  backend redirect (mispredict or jump); flushes the queue.
REQ-010 Port redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and treated as 00.
REQ-011 Port dq_valid  out  1  head entry available to decode.
REQ-012 Port dq_instr  out  32  head instruction word; drives DecodeControl instr.
REQ-013 Port dq_pc  out  32  PC of the head instruction; drives the branch-target pc.
REQ-014 Port dq_ready  in  1  decode accepts the head this cycle.

Function
REQ-015 At most one imem request SHALL be outstanding; a request is issued only when count < QDEPTH, so every non-dropped response has a free slot.
REQ-016 The FSM SHALL have three states: FETCH (imem_read=1), STALL (imem_read=0, queue full), DROP (imem_read=1, response to be discarded).
REQ-017 In FETCH, on imem_resp without redirect: enqueue {fetch_pc, imem_rdata} and set fetch_pc += 4 (mod 2^32).
  - If count after the edge < QDEPTH, stay in FETCH.
  - Otherwise go to STALL.
REQ-018 In STALL, the FSM SHALL return to FETCH on the edge where a dequeue occurs; imem_read rises the following cycle.
REQ-019 A dequeue occurs when dq_valid & dq_ready are both 1 at a rising edge; the head pointer advances and count decrements.
REQ-020 A simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-021 dq_valid SHALL equal (count != 0) & !redirect; dq_instr and dq_pc SHALL show the head entry combinationally.
REQ-022 Queue order SHALL be FIFO.
REQ-023 Pointers SHALL wrap modulo QDEPTH.
REQ-024 count SHALL range 0..QDEPTH.
REQ-025 On redirect (any state), at the clock edge:
  - count, head and tail are cleared.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - Any same-cycle dequeue or enqueue is discarded.
REQ-026 Redirect state transitions:
  - From FETCH without imem_resp in the same cycle: go to DROP.
  - From FETCH with imem_resp in the same cycle: the response is discarded; go to FETCH.
  - From STALL: go to FETCH.
REQ-027 In DROP, imem_address SHALL keep the pre-redirect address until imem_resp; that response is discarded, and the FSM goes to FETCH with the new fetch_pc.
REQ-028 A redirect during DROP SHALL update fetch_pc only and remain in DROP, unless imem_resp arrives in the same cycle, in which case go to FETCH.
REQ-029 The DROP address SHALL be held in a separate register so that imem_address stays stable while fetch_pc changes.
REQ-030 Fetch-to-decode latency SHALL be 1 cycle: a word enqueued at edge N is visible on dq_* in cycle N+1.

Reset
REQ-031 While rst=1: imem_read=0, dq_valid=0, count=0, pointers=0, state=FETCH, fetch_pc=RESET_PC.
REQ-032 rst SHALL override redirect, imem_resp and dq_ready.
REQ-033 The first cycle after rst falls SHALL show imem_read=1 and imem_address=RESET_PC.
REQ-034 If rst is asserted mid-request, that request is abandoned; the memory side tolerates request deassertion on reset.

Verification
REQ-035 Streaming: dq_ready=1, imem_resp one cycle after every request, rdata = address -> dq_pc sequence 0x40000060, 0x40000064, 0x40000068, ...; each dq_instr equals its dq_pc; no gaps after the first fill.
REQ-036 Full/stall: dq_ready=0 with QDEPTH=4 -> after 4 responses imem_read=0 and count=4; pulse dq_ready once -> dq_pc 0x40000060 consumed, imem_read=1 the next cycle at 0x40000070.
REQ-037 Redirect with request outstanding: redirect_pc=0x40000203 while waiting on 0x40000068 -> dq_valid=0 next cycle; imem_address stays 0x40000068 until resp; that word never appears; the next request is 0x40000200.
REQ-038 Redirect coincident with imem_resp and dq_ready=1 -> the resp word is not enqueued, count=0 after the edge, the next request is the redirect target.
REQ-039 Simultaneous enqueue and dequeue at count=QDEPTH-1 for 20 cycles -> count constant, pointers wrap correctly, order preserved.
REQ-040 rst pulsed during DROP with 3 entries queued -> all outputs per REQ-031; after release, a fresh fetch at RESET_PC.
